// File: rtl/gfx_mat_mul_seq_pkg.sv
// gfx_mat_mul_seq_pkg: FSM states, column-major element indexing and
// the shift/saturate rounding shared by the lane-shared matrix multiplier.
package gfx_mat_mul_seq_pkg;

  localparam int ACC_MAX = 64;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } mm_state_e;

  function automatic int elem_idx(
    input int r,
    input int c,
    input int n
  );
    return c * n + r;
  endfunction

  // arithmetic shift floors toward -inf before clamping to W bits
  function automatic logic signed [ACC_MAX-1:0] sat_round(
    input logic signed [ACC_MAX-1:0] acc,
    input int w,
    input int frac
  );
    logic signed [ACC_MAX-1:0] sh;
    logic signed [ACC_MAX-1:0] hi;
    logic signed [ACC_MAX-1:0] lo;
    sh = acc >>> frac;
    hi = (64'sd1 <<< (w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (sh > hi) return hi;
    if (sh < lo) return lo;
    return sh;
  endfunction

endpackage

// File: rtl/gfx_mat_mul_seq_if.sv
// gfx_mat_mul_seq_if: operand/result valid-ready bundle.
// GFX_MAT_MUL_ACC_EN adds the c addend matrix and acc_en.
interface gfx_mat_mul_seq_if #(
  parameter int N = 4,
  parameter int W = 16
);
  logic             in_valid;
  logic             in_ready;
  logic             out_valid;
  logic             out_ready;
  logic [N*N*W-1:0] a;
  logic [N*N*W-1:0] b;
  logic [N*N*W-1:0] q;
`ifdef GFX_MAT_MUL_ACC_EN
  logic [N*N*W-1:0] c;
  logic             acc_en;

  modport master (
    output in_valid, a, b, c, acc_en, out_ready,
    input  in_ready, out_valid, q
  );
  modport slave (
    input  in_valid, a, b, c, acc_en, out_ready,
    output in_ready, out_valid, q
  );
`else
  modport master (
    output in_valid, a, b, out_ready,
    input  in_ready, out_valid, q
  );
  modport slave (
    input  in_valid, a, b, out_ready,
    output in_ready, out_valid, q
  );
`endif
endinterface

// File: rtl/gfx_mat_col_mac.sv
// gfx_mat_col_mac: N signed multipliers and accumulators for one result
// column; sum is the running total including the current k-term.
module gfx_mat_col_mac #(
  parameter int N    = 4,
  parameter int W    = 16,
  parameter int ACCW = 34
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            en,
  input  logic [N*ACCW-1:0] init,
  input  logic [N*W-1:0]  a_col_k,
  input  logic [W-1:0]    b_kc,
  output logic [N*ACCW-1:0] sum
);

  logic [N*ACCW-1:0] acc;

  for (genvar r = 0; r < N; r++) begin : g_row
    logic signed [2*W-1:0] prod;
    assign prod = signed'(a_col_k[r*W +: W]) * signed'(b_kc);
    assign sum[r*ACCW +: ACCW] =
      acc[r*ACCW +: ACCW] + ACCW'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
    end else if (clr) begin
      acc <= init;
    end else if (en) begin
      acc <= sum;
    end
  end

endmodule

// File: rtl/gfx_mat_mul_seq.sv
// gfx_mat_mul_seq: NxN fixed-point q = a*b with LANES column units
// time-shared over the columns. GFX_MAT_MUL_ACC_EN adds q = a*b + c.
module gfx_mat_mul_seq
  import gfx_mat_mul_seq_pkg::*;
#(
  parameter int N     = 4,
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int LANES = 4
) (
  input  logic              clk,
  input  logic              rst,
  gfx_mat_mul_seq_if.slave  io,
  output logic              busy
);

  localparam int P    = (N + LANES - 1) / LANES;
  localparam int KW   = $clog2(N);
  localparam int PW   = $clog2(P + 1);
  localparam int ACCW = 2 * W + $clog2(N);
  localparam int MW   = N * N * W;

  mm_state_e       state;
  logic [KW-1:0]   k;
  logic [PW-1:0]   pass;
  logic [MW-1:0]   a_r;
  logic [MW-1:0]   b_r;
  logic [MW-1:0]   q_r;
  logic            in_ready;
  logic            out_valid;
  logic            accept;
  logic            last_k;
  logic [LANES-1:0] ok;
  int              colv [LANES];
  logic [W-1:0]    res [LANES][N];
`ifdef GFX_MAT_MUL_ACC_EN
  logic [MW-1:0]   c_r;
  logic            acc_en_r;
`endif

  assign accept       = state == IDLE && io.in_valid && in_ready;
  assign last_k       = k == KW'(N - 1);
  assign io.in_ready  = in_ready;
  assign io.out_valid = out_valid;
  assign io.q         = q_r;

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [N*W-1:0]    a_col;
    logic [W-1:0]      b_kc;
    logic [N*ACCW-1:0] init;
    logic [N*ACCW-1:0] sum;
    int                col;
    int                cs;

    assign col     = int'(pass) * LANES + l;
    assign ok[l]   = col < N;
    assign cs      = ok[l] ? col : 0;
    assign colv[l] = cs;
    assign b_kc    = b_r[elem_idx(int'(k), cs, N)*W +: W];

    for (genvar r = 0; r < N; r++) begin : g_row
      assign a_col[r*W +: W] = a_r[elem_idx(r, int'(k), N)*W +: W];
      assign res[l][r] = W'(sat_round(
        ACC_MAX'(signed'(sum[r*ACCW +: ACCW])), W, FRAC));
    end

`ifdef GFX_MAT_MUL_ACC_EN
    // init is loaded at accept (pass 0, live ports) and at each
    // pass end for the column this lane handles next
    logic [MW-1:0] csrc;
    logic          ien;
    int            icol;
    always_comb begin
      if (state == IDLE) begin
        icol = l;
        ien  = io.acc_en;
        csrc = io.c;
      end else begin
        icol = (int'(pass) + 1) * LANES + l;
        ien  = acc_en_r;
        csrc = c_r;
      end
      if (icol >= N) icol = 0;
    end
    for (genvar r = 0; r < N; r++) begin : g_init
      assign init[r*ACCW +: ACCW] = ien ?
        ACCW'(signed'(csrc[elem_idx(r, icol, N)*W +: W])) << FRAC :
        '0;
    end
`else
    assign init = '0;
`endif

    gfx_mat_col_mac #(
      .N    (N),
      .W    (W),
      .ACCW (ACCW)
    ) u_mac (
      .clk     (clk),
      .rst     (rst),
      .clr     (accept || (state == RUN && last_k)),
      .en      (state == RUN && ok[l]),
      .init    (init),
      .a_col_k (a_col),
      .b_kc    (b_kc),
      .sum     (sum)
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      k         <= '0;
      pass      <= '0;
      a_r       <= '0;
      b_r       <= '0;
      q_r       <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef GFX_MAT_MUL_ACC_EN
      c_r       <= '0;
      acc_en_r  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          in_ready <= 1'b1;
          if (accept) begin
            a_r      <= io.a;
            b_r      <= io.b;
`ifdef GFX_MAT_MUL_ACC_EN
            c_r      <= io.c;
            acc_en_r <= io.acc_en;
`endif
            k        <= '0;
            pass     <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          // one idle cycle after the last pass lets q settle
          if (pass == PW'(P)) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else if (last_k) begin
            k    <= '0;
            pass <= pass + 1'b1;
            for (int l = 0; l < LANES; l++) begin
              if (ok[l]) begin
                for (int r = 0; r < N; r++) begin
                  q_r[elem_idx(r, colv[l], N)*W +: W] <= res[l][r];
                end
              end
            end
          end else begin
            k <= k + 1'b1;
          end
        end
        DONE: begin
          if (io.out_ready) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
